// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, key-expansion FSM states, GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned ROUND_W = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand128_if.sv
// Init/ready handshake plus round-key read port between the cipher and key expander.
interface aes_key_expand128_if;
  import aes_pkg::*;

  logic               init;
  logic [KEY_W-1:0]   key;
  logic [ROUND_W-1:0] round;
  logic [KEY_W-1:0]   round_key;
  logic               ready;

  modport master (
    output init, key, round,
    input  round_key, ready
  );

  modport slave (
    input  init, key, round,
    output round_key, ready
  );

endinterface

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel AES S-box byte lookups.
module aes_sbox_word (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub_word = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_expand128.sv
// AES-128 key expander: captures a cipher key on init and produces one round key
// per clock into an 11-entry register file read combinationally by round index.
module aes_key_expand128
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  aes_key_expand128_if.slave bus
);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   cnt_q, cnt_d;
  logic [7:0]           rcon_q, rcon_d;
  logic [KEY_W-1:0]     w_q, w_d;
  logic [KEY_W-1:0]     rk [NR+1];

  logic                 rk_we;
  logic [ROUND_W-1:0]   rk_idx;
  logic [KEY_W-1:0]     rk_data;

  logic [31:0]          rot, sub, t, w0, w1, w2, w3;
  logic [KEY_W-1:0]     next_w;

  // One FIPS-197 key-schedule step from the previous round key.
  assign rot = {w_q[23:0], w_q[31:24]};

  aes_sbox_word u_sbox (
    .word     (rot),
    .sub_word (sub)
  );

  assign t      = sub ^ {rcon_q, 24'h0};
  assign w0     = w_q[127:96] ^ t;
  assign w1     = w_q[95:64]  ^ w0;
  assign w2     = w_q[63:32]  ^ w1;
  assign w3     = w_q[31:0]   ^ w2;
  assign next_w = {w0, w1, w2, w3};

  // Ready is exactly "in IDLE": it drops on the accepting edge and rises on the edge writing rk[NR].
  assign bus.ready     = (state_q == IDLE);
  assign bus.round_key = (bus.round <= ROUND_W'(NR)) ? rk[bus.round] : '0;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    rk_we   = 1'b0;
    rk_idx  = cnt_q;
    rk_data = next_w;
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          state_d = EXPAND;
          cnt_d   = ROUND_W'(1);
          rcon_d  = RCON_INIT;
          w_d     = bus.key;
          rk_we   = 1'b1;
          rk_idx  = '0;
          rk_data = bus.key;
        end
      end
      EXPAND: begin
        rk_we  = 1'b1;
        w_d    = next_w;
        cnt_d  = cnt_q + ROUND_W'(1);
        rcon_d = xtime(rcon_q);
        if (cnt_q == ROUND_W'(NR)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working key, counter and rcon registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcon_q  <= RCON_INIT;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      w_q     <= w_d;
    end
  end

  // Round-key register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (rk_we) begin
      rk[rk_idx] <= rk_data;
    end
  end

endmodule

// File: doc/aes_key_expand128.md
Name: aes_key_expand128

Overview:
- Responder end of the init/ready handshake used by the AES-128 encryption flow.
- On an init request, it captures a 128-bit cipher key and expands it iteratively into the 11 FIPS-197 round keys, producing one round key per clock.
- It holds the round keys in a register file that the cipher datapath reads by round index.
- It drops ready while expanding and raises it when all round keys are valid, matching the wait-for-ready sequencing of the encryption bench.

Parameters:
- NR, 10, number of cipher rounds; round keys 0..NR are stored. Fixed for AES-128 and not overridable in practice.
- KEY_W, 128, key and round-key width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  request key expansion; sampled only when ready=1.
- key  input  128  cipher key; sampled on the edge that accepts init.
- round  input  4  round-key read index, 0..10.
- round_key  output  128  combinational read of the stored round key selected by round.
- ready  output  1  1 = idle and all stored round keys valid; 0 = expansion in progress.

Behaviour:
- Reset (async, active-high):
  - ready=1, FSM=IDLE, round counter=0, rcon register=8'h01.
  - All 11 round-key registers cleared to 0, so round_key reads 0 for any index.
- FSM states: IDLE, EXPAND.
- IDLE:
  - On an edge with init=1: rk[0] <= key; working word set W <= key; counter <= 1; rcon <= 8'h01; ready <= 0; go to EXPAND.
  - init=0: hold.
- EXPAND, each edge:
  - t = SubWord(RotWord(W[31:0])) ^ {rcon,24'h0}.
  - w0' = W[127:96]^t; w1' = W[95:64]^w0'; w2' = W[63:32]^w1'; w3' = W[31:0]^w2'.
  - rk[counter] <= {w0',w1',w2',w3'}; W <= same value.
  - counter += 1; rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Sequence 01,02,04,08,10,20,40,80,1b,36.
  - When counter=10 is written: go to IDLE and set ready <= 1 on that same edge.
- Latency: init accepted at edge E; ready=0 after edges E..E+9; ready=1 after edge E+10. Ready is low for exactly 10 cycles.
- init while ready=0: ignored, with no effect on the counter or the keys.
- init held high across the return to IDLE: a new expansion starts on the first edge with ready=1 and init=1. Requesters deassert init after acceptance; the bench holds it 2 cycles, and the second cycle is ignored.
- key changes during EXPAND: no effect; only the value captured at acceptance is used.
- Reads during EXPAND:
  - Indices already written return the new keys.
  - Indices not yet written return the previous expansion's keys (or 0 after reset).
  - The consumer must wait for ready=1.
- round > 10: round_key = 128'h0.
- Reset asserted mid-expansion: immediate return to the reset state; the partial expansion is discarded.
- round_key has no pipeline stage: a pure mux from the register file.

Decomposition:
- Shared package aes_pkg:
  - NR=10 and KEY_W=128.
  - FSM state encoding {IDLE, EXPAND}.
  - xtime function.
  - RCON_INIT=8'h01.
- Sub-module aes_sbox_word:
  - 32-bit combinational SubWord built from four 256-entry S-box lookups.
  - Shared with the cipher datapath's SubBytes.
  - Instantiated once here.

Test Plan:
- Reset: assert reset mid-cycle -> ready=1 immediately, round_key=0 for round 0..10.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, init for 1 cycle:
  - ready low for exactly 10 cycles.
  - Then rk0=2b7e151628aed2a6abf7158809cf4f3c.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk1=62636363626363636263636362636363.
  - rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
  - round=11 and round=15 -> round_key=0.
- Busy-init and key-change rejection:
  - Start the FIPS key.
  - Pulse init with the zero key at cycle 4 of expansion -> ignored; final rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Then hold init=1 for 2 cycles with the zero key -> exactly one expansion; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-expansion:
  - Assert reset at cycle 5 of the FIPS-key expansion -> ready=1, all keys 0.
  - New init with the FIPS key -> correct rk1 and rk10, with 10-cycle latency.
